usb_port_connect_sequencer: RTL and testbench
=============================================

Name: usb_port_connect_sequencer

Overview:
- Downstream-port connection controller for the hub.
- Watches raw line state, debounces device attach, latches speed and J/K encoding, and sequences the bus reset (drives SE0) and reset recovery.
- Enables the port and detects disconnect.
- Feeds line-encoding (j_state/k_state/idle_state) and port status to the hub's packet and status logic.

Parameters:
- DEBOUNCE_TICKS, 100, consecutive stable-attach cycles required before a connect is declared.
- RESET_TICKS, 50, cycles drive_se0 is held during a bus reset.
- RECOVERY_TICKS, 10, cycles after reset release before the line is sampled for enable.
- DISCONNECT_TICKS, 20, consecutive SE0 cycles that declare a disconnect.
- SUSPEND_TICKS, 300, consecutive idle-J cycles before suspend (optional feature only).

Ports:
- clock  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- usb_signals  in  2  line state; [1]=D+, [0]=D-; 00 = SE0, 11 = SE1.
- port_reset_req  in  1  level; request a bus reset on a connected port.
- port_disable  in  1  level; drop enable and return to WAIT_RESET.
- drive_se0  out  1  transceiver drives SE0 while high.
- connected  out  1  device attached and debounced.
- port_enabled  out  1  port in ENABLED state.
- low_speed  out  1  1 = low-speed device (J = 01); 0 = full-speed (J = 10).
- j_state  out  2  latched J encoding.
- k_state  out  2  latched K encoding.
- idle_state  out  2  equals j_state.
- reset_done  out  1  one-cycle pulse on entry to ENABLED.
- port_state  out  3  current state encoding, for status/debug.

Behaviour:
- Reset (reset_n low, async): state DISCONNECTED, all counters 0. Outputs: drive_se0/connected/port_enabled/low_speed/reset_done = 0; j_state = idle_state = 10; k_state = 01.
- All outputs are registered. A state change is visible on outputs the cycle after the triggering sample.
- Counter width is $clog2(max tick parameter + 1). The counter clears on every state entry and saturates; it never wraps.
- DISCONNECTED: usb_signals = 10 or 01 -> DEBOUNCE, capturing that value as the candidate J. 00/11 stay. Requests are ignored.
- DEBOUNCE: any sample != candidate -> DISCONNECTED. Counter reaching DEBOUNCE_TICKS-1 with a matching sample -> WAIT_RESET, and on the same edge:
  - connected = 1
  - j_state = idle_state = candidate; k_state = inverted candidate
  - low_speed = (candidate == 01)
- WAIT_RESET: DISCONNECT_TICKS consecutive SE0 -> DISCONNECTED, clearing connected. Otherwise port_reset_req -> BUS_RESET. Disconnect wins if both occur on the same cycle.
- BUS_RESET: drive_se0 = 1. Line is ignored (SE0 is self-driven). After RESET_TICKS cycles -> RECOVERY, with drive_se0 = 0 on that edge. port_disable/port_reset_req are ignored here.
- RECOVERY: wait RECOVERY_TICKS cycles, then sample once:
  - sample == j_state -> ENABLED, port_enabled = 1, reset_done pulses 1 cycle.
  - otherwise -> DISCONNECTED, connected = 0.
- ENABLED, priority order:
  1. DISCONNECT_TICKS consecutive SE0 -> DISCONNECTED (port_enabled = connected = 0).
  2. port_reset_req -> BUS_RESET (port_enabled = 0).
  3. port_disable -> WAIT_RESET (port_enabled = 0).
- The SE0 run counter restarts on any non-SE0 sample. Short SE0 (EOP) never disconnects.
- j/k/low_speed hold their last latched values until the next successful debounce.
- State encoding: DISCONNECTED 0, DEBOUNCE 1, WAIT_RESET 2, BUS_RESET 3, RECOVERY 4, ENABLED 5, SUSPENDED 6.

Optional Feature:
- Macro: USB_PORT_SUSPEND_EN.
- Defined:
  - ENABLED with SUSPEND_TICKS consecutive samples == idle_state -> SUSPENDED; port_enabled stays 1.
  - SUSPENDED: a sample == k_state (resume) -> ENABLED (no reset_done pulse).
  - SUSPENDED: DISCONNECT_TICKS SE0 -> DISCONNECTED.
  - SUSPENDED: port_reset_req -> BUS_RESET.
- Undefined: no SUSPENDED state and no idle counter. Code 6 is unreachable and any illegal state recovers to DISCONNECTED.

Decomposition:
- Shared package usb_hub_pkg holds:
  - line-state constants LINE_SE0 = 00, LINE_FS_J = 10, LINE_LS_J = 01, LINE_SE1 = 11;
  - the port-state enum and its 3-bit encoding.
- One sub-module, usb_line_run_counter: a saturating counter with a match input, clear and terminal-count compare. Instantiated for the state timer and the SE0 run; a third instance is the idle run under the macro.

Test Plan:
- Full-speed attach: hold 10 for 100 cycles -> connected = 1, low_speed = 0, j = 10, k = 01, port_state = 2.
- Bounce: 10 for 60 cycles, 00 for 1, then 10 -> DEBOUNCE restarts; connected rises only 100 cycles after the restart.
- Low-speed reset/enable: attach 01, pulse port_reset_req -> drive_se0 high exactly 50 cycles; 10 cycles later with line 01 -> port_enabled = 1, reset_done pulses once.
- Disconnect filtering in ENABLED: 2-cycle SE0 (EOP) -> stays enabled; 20-cycle SE0 -> port_state = 0, connected = port_enabled = 0.
- Priority: SE0 run completes on the same cycle port_reset_req rises -> DISCONNECTED, drive_se0 never asserts. Separately, reset_n low mid BUS_RESET -> drive_se0 = 0 immediately (async).
- With USB_PORT_SUSPEND_EN: enabled, idle J for 300 cycles -> port_state = 6; one K sample -> port_state = 5, no reset_done.

Source files
------------

// File: rtl/usb_hub_pkg.sv
// Shared hub definitions: raw line-state codes and the downstream-port state encoding.
package usb_hub_pkg;

  localparam logic [1:0] LINE_SE0  = 2'b00;
  localparam logic [1:0] LINE_FS_J = 2'b10;
  localparam logic [1:0] LINE_LS_J = 2'b01;
  localparam logic [1:0] LINE_SE1  = 2'b11;

  typedef enum logic [2:0] {
    PS_DISCONNECTED = 3'd0,
    PS_DEBOUNCE     = 3'd1,
    PS_WAIT_RESET   = 3'd2,
    PS_BUS_RESET    = 3'd3,
    PS_RECOVERY     = 3'd4,
    PS_ENABLED      = 3'd5,
    PS_SUSPENDED    = 3'd6
  } port_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_line_run_counter.sv
// Saturating run counter: counts consecutive match cycles, zeroes on clear or mismatch.
// hit_o flags the sample that completes a run of term_i+1 matches.
module usb_line_run_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         match_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !match_i) cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign hit_o = match_i && (cnt_q == term_i);

endmodule

// File: rtl/usb_port_connect_sequencer.sv
// Downstream-port connect/reset/enable sequencer with latched J/K line encoding.
// Define USB_PORT_SUSPEND_EN to add the idle-driven SUSPENDED state.
module usb_port_connect_sequencer
  import usb_hub_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS   = 100,
  parameter int unsigned RESET_TICKS      = 50,
  parameter int unsigned RECOVERY_TICKS   = 10,
  parameter int unsigned DISCONNECT_TICKS = 20,
  parameter int unsigned SUSPEND_TICKS    = 300
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] usb_signals,
  input  logic       port_reset_req,
  input  logic       port_disable,
  output logic       drive_se0,
  output logic       connected,
  output logic       port_enabled,
  output logic       low_speed,
  output logic [1:0] j_state,
  output logic [1:0] k_state,
  output logic [1:0] idle_state,
  output logic       reset_done,
  output logic [2:0] port_state
);

  localparam int unsigned MAXT = max_u(max_u(DEBOUNCE_TICKS, RESET_TICKS),
                                       max_u(RECOVERY_TICKS, max_u(DISCONNECT_TICKS, SUSPEND_TICKS)));
  localparam int unsigned CW   = $clog2(MAXT + 1);

  port_state_e state_q, state_d;
  logic [1:0]  cand_q, cand_d, j_q, j_d, k_q, k_d;
  logic        ls_q, ls_d, conn_q, conn_d, en_q, en_d, se0_q, se0_d, rd_q, rd_d;
  logic [CW-1:0] tmr_term;
  logic        tmr_hit, se0_hit, enter;

  assign enter = (state_d != state_q);

  // Debounce fires when the count *reaches* DEBOUNCE_TICKS-1, i.e. on the
  // DEBOUNCE_TICKS-th matching sample counting the one that entered DEBOUNCE.
  always_comb begin
    tmr_term = '0;
    case (state_q)
      PS_DEBOUNCE:  tmr_term = CW'(DEBOUNCE_TICKS - 2);
      PS_BUS_RESET: tmr_term = CW'(RESET_TICKS - 1);
      PS_RECOVERY:  tmr_term = CW'(RECOVERY_TICKS - 1);
      default:      tmr_term = '0;
    endcase
  end

  usb_line_run_counter #(.W(CW)) u_tmr (
    .clock(clock), .reset_n(reset_n), .clr_i(enter), .match_i(1'b1),
    .term_i(tmr_term), .hit_o(tmr_hit));

  usb_line_run_counter #(.W(CW)) u_se0 (
    .clock(clock), .reset_n(reset_n), .clr_i(enter), .match_i(usb_signals == LINE_SE0),
    .term_i(CW'(DISCONNECT_TICKS - 1)), .hit_o(se0_hit));

`ifdef USB_PORT_SUSPEND_EN
  logic idle_hit;
  usb_line_run_counter #(.W(CW)) u_idle (
    .clock(clock), .reset_n(reset_n), .clr_i(enter), .match_i(usb_signals == j_q),
    .term_i(CW'(SUSPEND_TICKS - 1)), .hit_o(idle_hit));
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    case (state_q)
      PS_DISCONNECTED:
        if (usb_signals == LINE_FS_J || usb_signals == LINE_LS_J) begin
          state_d = PS_DEBOUNCE;
          cand_d  = usb_signals;
        end
      PS_DEBOUNCE:
        if (usb_signals != cand_q) state_d = PS_DISCONNECTED;
        else if (tmr_hit)          state_d = PS_WAIT_RESET;
      PS_WAIT_RESET:
        if (se0_hit)             state_d = PS_DISCONNECTED;
        else if (port_reset_req) state_d = PS_BUS_RESET;
      PS_BUS_RESET:
        if (tmr_hit) state_d = PS_RECOVERY;
      PS_RECOVERY:
        if (tmr_hit) state_d = (usb_signals == j_q) ? PS_ENABLED : PS_DISCONNECTED;
      PS_ENABLED:
        if (se0_hit)             state_d = PS_DISCONNECTED;
        else if (port_reset_req) state_d = PS_BUS_RESET;
        else if (port_disable)   state_d = PS_WAIT_RESET;
`ifdef USB_PORT_SUSPEND_EN
        else if (idle_hit)       state_d = PS_SUSPENDED;
      PS_SUSPENDED:
        if (se0_hit)                   state_d = PS_DISCONNECTED;
        else if (port_reset_req)       state_d = PS_BUS_RESET;
        else if (usb_signals == k_q)   state_d = PS_ENABLED;
`endif
      default: state_d = PS_DISCONNECTED;
    endcase

    j_d  = j_q;
    k_d  = k_q;
    ls_d = ls_q;
    if (state_q == PS_DEBOUNCE && state_d == PS_WAIT_RESET) begin
      j_d  = cand_q;
      k_d  = ~cand_q;
      ls_d = (cand_q == LINE_LS_J);
    end
    conn_d = !(state_d inside {PS_DISCONNECTED, PS_DEBOUNCE});
    en_d   = (state_d inside {PS_ENABLED, PS_SUSPENDED});
    se0_d  = (state_d == PS_BUS_RESET);
    rd_d   = (state_q == PS_RECOVERY) && (state_d == PS_ENABLED);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= PS_DISCONNECTED;
      cand_q  <= LINE_FS_J;
      j_q     <= LINE_FS_J;
      k_q     <= LINE_LS_J;
      ls_q    <= 1'b0;
      conn_q  <= 1'b0;
      en_q    <= 1'b0;
      se0_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      j_q     <= j_d;
      k_q     <= k_d;
      ls_q    <= ls_d;
      conn_q  <= conn_d;
      en_q    <= en_d;
      se0_q   <= se0_d;
      rd_q    <= rd_d;
    end

  assign drive_se0    = se0_q;
  assign connected    = conn_q;
  assign port_enabled = en_q;
  assign low_speed    = ls_q;
  assign j_state      = j_q;
  assign k_state      = k_q;
  assign idle_state   = j_q;
  assign reset_done   = rd_q;
  assign port_state   = state_q;

endmodule

// File: tb/tb_usb_port_connect_sequencer.sv
// Directed bench for the port connect sequencer: attach, bounce, reset/enable,
// disconnect filtering, priority and async reset.
module tb_usb_port_connect_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] usb_signals;
  logic       port_reset_req, port_disable;
  logic       drive_se0, connected, port_enabled, low_speed, reset_done;
  logic [1:0] j_state, k_state, idle_state;
  logic [2:0] port_state;

  int n_run = 0;
  int n_fail = 0;

  usb_port_connect_sequencer dut (
    .clock(clock), .reset_n(reset_n), .usb_signals(usb_signals),
    .port_reset_req(port_reset_req), .port_disable(port_disable),
    .drive_se0(drive_se0), .connected(connected), .port_enabled(port_enabled),
    .low_speed(low_speed), .j_state(j_state), .k_state(k_state),
    .idle_state(idle_state), .reset_done(reset_done), .port_state(port_state));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; usb_signals = 2'b00; port_reset_req = 1'b0; port_disable = 1'b0;
    cyc(2);
    chk("rst_state", 32'(port_state), 0);
    chk("rst_se0",   32'(drive_se0), 0);
    chk("rst_conn",  32'(connected), 0);
    chk("rst_en",    32'(port_enabled), 0);
    chk("rst_ls",    32'(low_speed), 0);
    chk("rst_rd",    32'(reset_done), 0);
    chk("rst_j",     32'(j_state), 32'h2);
    chk("rst_k",     32'(k_state), 32'h1);
    chk("rst_idle",  32'(idle_state), 32'h2);
    reset_n = 1'b1;

    // SE0 and SE1 never start a debounce; requests ignored
    port_reset_req = 1'b1; cyc(3);
    chk("disc_se0", 32'(port_state), 0);
    usb_signals = 2'b11; cyc(3);
    chk("disc_se1", 32'(port_state), 0);
    chk("disc_noreset", 32'(drive_se0), 0);
    port_reset_req = 1'b0;

    // full-speed attach: 100 stable samples
    usb_signals = 2'b10; cyc(99);
    chk("fs_conn_early", 32'(connected), 0);
    chk("fs_state_deb",  32'(port_state), 1);
    cyc(1);
    chk("fs_conn",  32'(connected), 1);
    chk("fs_ls",    32'(low_speed), 0);
    chk("fs_j",     32'(j_state), 32'h2);
    chk("fs_k",     32'(k_state), 32'h1);
    chk("fs_state", 32'(port_state), 2);

    // disconnect from WAIT_RESET after 20 SE0
    usb_signals = 2'b00; cyc(19);
    chk("wr_se0_19", 32'(port_state), 2);
    cyc(1);
    chk("wr_disc", 32'(port_state), 0);
    chk("wr_conn", 32'(connected), 0);

    // bounce restarts the debounce
    usb_signals = 2'b10; cyc(60);
    usb_signals = 2'b00; cyc(1);
    chk("bounce_disc", 32'(port_state), 0);
    usb_signals = 2'b10; cyc(99);
    chk("bounce_early", 32'(connected), 0);
    cyc(1);
    chk("bounce_conn", 32'(connected), 1);
    usb_signals = 2'b00; cyc(20);
    chk("bounce_drop", 32'(port_state), 0);

    // low-speed attach, bus reset, recovery, enable
    usb_signals = 2'b01; cyc(100);
    chk("ls_conn", 32'(connected), 1);
    chk("ls_ls",   32'(low_speed), 1);
    chk("ls_j",    32'(j_state), 32'h1);
    chk("ls_k",    32'(k_state), 32'h2);
    chk("ls_idle", 32'(idle_state), 32'h1);
    port_reset_req = 1'b1; cyc(1); port_reset_req = 1'b0; usb_signals = 2'b00;
    chk("br_se0_first", 32'(drive_se0), 1);
    chk("br_state", 32'(port_state), 3);
    cyc(49);
    chk("br_se0_last", 32'(drive_se0), 1);
    cyc(1);
    chk("br_se0_off", 32'(drive_se0), 0);
    chk("rec_state", 32'(port_state), 4);
    usb_signals = 2'b01; cyc(9);
    chk("rec_en_early", 32'(port_enabled), 0);
    cyc(1);
    chk("en_en",    32'(port_enabled), 1);
    chk("en_rd",    32'(reset_done), 1);
    chk("en_state", 32'(port_state), 5);
    cyc(1);
    chk("en_rd_pulse", 32'(reset_done), 0);

    // EOP-length SE0 keeps the port, a full run disconnects
    usb_signals = 2'b00; cyc(2); usb_signals = 2'b01; cyc(1);
    chk("eop_keep", 32'(port_state), 5);
    chk("eop_en",   32'(port_enabled), 1);
    usb_signals = 2'b00; cyc(19);
    chk("en_se0_19", 32'(port_state), 5);
    cyc(1);
    chk("en_disc",      32'(port_state), 0);
    chk("en_disc_conn", 32'(connected), 0);
    chk("en_disc_en",   32'(port_enabled), 0);

    // SE0 run completion beats a simultaneous reset request
    usb_signals = 2'b01; cyc(100);
    chk("pri_wr", 32'(port_state), 2);
    usb_signals = 2'b00; cyc(19);
    port_reset_req = 1'b1; cyc(1);
    chk("pri_state", 32'(port_state), 0);
    chk("pri_se0",   32'(drive_se0), 0);
    cyc(1);
    chk("pri_se0_after", 32'(drive_se0), 0);
    port_reset_req = 1'b0;

    // re-enable, then disable back to WAIT_RESET
    usb_signals = 2'b01; cyc(100);
    port_reset_req = 1'b1; cyc(1); port_reset_req = 1'b0; usb_signals = 2'b00;
    cyc(49); usb_signals = 2'b01; cyc(11);
    chk("en2_state", 32'(port_state), 5);
    chk("en2_rd",    32'(reset_done), 1);
    cyc(1);
`ifdef USB_PORT_SUSPEND_EN
    cyc(298);
    chk("sus_early", 32'(port_state), 5);
    cyc(1);
    chk("sus_state", 32'(port_state), 6);
    chk("sus_en",    32'(port_enabled), 1);
    usb_signals = 2'b10; cyc(1);
    chk("resume_state", 32'(port_state), 5);
    chk("resume_rd",    32'(reset_done), 0);
    usb_signals = 2'b01;
`endif
    port_disable = 1'b1; cyc(1); port_disable = 1'b0;
    chk("dis_state", 32'(port_state), 2);
    chk("dis_en",    32'(port_enabled), 0);
    chk("dis_conn",  32'(connected), 1);

    // async reset in the middle of a bus reset
    port_reset_req = 1'b1; cyc(1); port_reset_req = 1'b0;
    chk("br2_se0", 32'(drive_se0), 1);
    cyc(10);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_se0",   32'(drive_se0), 0);
    chk("arst_state", 32'(port_state), 0);
    chk("arst_conn",  32'(connected), 0);
    chk("arst_j",     32'(j_state), 32'h2);
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    chk("arst_hold", 32'(port_state), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
